// File: rtl/reg_file_scanner.sv
// Debug/boot sequencer owning the register-file ports while busy: DUMP streams r0..r31 out,
// LOAD writes 31 incoming words into r1..r31. One beat/word per cycle at full throughput.
module reg_file_scanner #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dump_req,
    input  logic                  load_req,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rf_raddr,
    input  logic [DATA_WIDTH-1:0] rf_rdata,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_last,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data
);

    typedef enum logic [1:0] {IDLE, DUMP, LOAD, DONE} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH:0]   fcnt;
    logic [ADDR_WIDTH-1:0] wcnt;
    logic                  fetch;
    logic                  last_acc;
    logic                  wr_acc;
    logic                  last_wr;

    // The extra MSB of fcnt marks "every register fetched"
    assign fetch    = (state == DUMP) && (!out_valid || out_ready) && !fcnt[ADDR_WIDTH];
    assign last_acc = (state == DUMP) && out_valid && out_ready && out_last;
    assign wr_acc   = (state == LOAD) && in_valid;
    assign last_wr  = wr_acc && (wcnt == {ADDR_WIDTH{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (dump_req) begin
                    state_nxt = DUMP;
                end else if (load_req) begin
                    state_nxt = LOAD;
                end
            end
            DUMP: if (last_acc) state_nxt = DONE;
            LOAD: if (last_wr) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        done     = (state == DONE);
        in_ready = (state == LOAD);
        rf_raddr = (state == DUMP) ? fcnt[ADDR_WIDTH-1:0] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt      <= '0;
            wcnt      <= ADDR_WIDTH'(1);
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            out_last  <= 1'b0;
            rf_wen    <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
        end else begin
            // Counters are re-armed for the whole IDLE period, so they are fresh on entry
            if (state == IDLE) begin
                fcnt <= '0;
                wcnt <= ADDR_WIDTH'(1);
            end
            if (fetch) begin
                fcnt <= fcnt + 1'b1;
            end
            if (wr_acc) begin
                wcnt <= wcnt + 1'b1;
            end

            if (state != DUMP) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else if (fetch) begin
                out_valid <= 1'b1;
                out_data  <= rf_rdata;
                out_addr  <= fcnt[ADDR_WIDTH-1:0];
                out_last  <= (fcnt[ADDR_WIDTH-1:0] == {ADDR_WIDTH{1'b1}});
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end

            // wcnt starts at 1, so a write never targets r0
            rf_wen <= wr_acc;
            if (wr_acc) begin
                rf_waddr <= wcnt;
                rf_wdata <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_scanner.sv
// Bench for reg_file_scanner: behavioural register file plus a transaction-level model
// (beats fetched/accepted, words accepted) compared against the DUT every cycle.
module tb_reg_file_scanner;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          dump_req, load_req;
    logic          busy, done;
    logic [AW-1:0] rf_raddr;
    logic [DW-1:0] rf_rdata;
    logic          rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_last;
    logic          in_valid, in_ready;
    logic [DW-1:0] in_data;

    always #5 clk = ~clk;

    reg_file_scanner #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .dump_req(dump_req), .load_req(load_req),
        .busy(busy), .done(done), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_last(out_last),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data)
    );

    // Environment register file: combinational read, r0 reads zero
    logic [DW-1:0] rf [32];
    always @(posedge clk) if (rf_wen && rf_waddr != 0) rf[rf_waddr] <= rf_wdata;
    assign rf_rdata = (rf_raddr == 0) ? '0 : rf[rf_raddr];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tmo(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout t=%0t", name, $time);
    endtask

    // Model: mode 0 idle, 1 dump, 2 load, 3 done
    int            m_mode, m_f, m_a, m_w;
    logic          e_wen;
    logic [4:0]    e_waddr;
    logic [31:0]   e_wdata;
    logic [31:0]   mdl_mem [32];
    bit            chk_en = 0;
    int            acc_out = 0, acc_in = 0, done_cnt = 0, last_cnt = 0;
    logic [31:0]   cap_data [$];
    logic [4:0]    cap_addr [$];

    always @(negedge clk) begin
        bit ev, acc, ld;
        ev = (m_mode == 1) && (m_f > m_a);
        if (chk_en) begin
            chk("busy", busy, m_mode != 0);
            chk("done", done, m_mode == 3);
            chk("in_ready", in_ready, m_mode == 2);
            chk("out_valid", out_valid, ev);
            chk("out_last", out_last, ev && m_a == 31);
            chk("rf_wen", rf_wen, e_wen);
            chk("rf_raddr", rf_raddr, (m_mode == 1) ? (m_f % 32) : 0);
            if (ev) begin
                chk("out_data", out_data, mdl_mem[m_a]);
                chk("out_addr", out_addr, m_a);
            end
            if (e_wen) begin
                chk("rf_waddr", rf_waddr, e_waddr);
                chk("rf_wdata", rf_wdata, e_wdata);
            end
        end
        if (!rst) begin
            if (out_valid && out_ready) begin
                acc_out++;
                cap_data.push_back(out_data);
                cap_addr.push_back(out_addr);
                if (out_last) last_cnt++;
            end
            if (in_valid && in_ready) acc_in++;
            if (done) done_cnt++;
        end
        // Advance the model to the state after the coming edge
        if (e_wen && e_waddr != 0) mdl_mem[e_waddr] = e_wdata;
        if (rst) begin
            m_mode = 0; m_f = 0; m_a = 0; m_w = 0; e_wen = 0;
        end else begin
            case (m_mode)
                0: begin
                    e_wen = 0;
                    if (dump_req) begin m_mode = 1; m_f = 0; m_a = 0; end
                    else if (load_req) begin m_mode = 2; m_w = 0; end
                end
                1: begin
                    e_wen = 0;
                    acc = ev && out_ready;
                    ld  = !ev || out_ready;
                    if (ld && m_f < 32) m_f++;
                    if (acc) begin
                        if (m_a == 31) m_mode = 3;
                        m_a++;
                    end
                end
                2: begin
                    if (in_valid) begin
                        e_wen = 1; e_waddr = 5'(m_w + 1); e_wdata = in_data;
                        m_w++;
                        if (m_w == 31) m_mode = 3;
                    end else begin
                        e_wen = 0;
                    end
                end
                default: begin m_mode = 0; e_wen = 0; end
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_check();
        rst = 1'b1;
        step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_rf_raddr", rf_raddr, 0);
        chk("rst_rf_wen", rf_wen, 0);
        chk("rst_rf_waddr", rf_waddr, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        rst = 1'b0;
    endtask

    task automatic run_dump(input int rmode, input int rst_after, input bit both);
        int n, a0;
        a0 = acc_out;
        cap_data.delete();
        cap_addr.delete();
        dump_req = 1'b1;
        load_req = both;
        step();
        dump_req = 1'b0;
        if (both) chk("both_in_ready", in_ready, 0);
        n = 0;
        while (busy && n < 600) begin
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = (n % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (rst_after >= 0 && acc_out - a0 >= rst_after) begin
                reset_check();
                break;
            end
            step();
            n++;
        end
        if (n >= 600) tmo("dump_busy");
        out_ready = 1'b0;
        load_req  = 1'b0;
    endtask

    task automatic run_load(input int vmode, input int stop_after, input logic [31:0] base,
                            output int cycles);
        int n, a0, k;
        a0 = acc_in;
        load_req = 1'b1;
        step();
        load_req = 1'b0;
        n = 0;
        while (busy && n < 600) begin
            k = acc_in - a0;
            if (stop_after >= 0 && k >= stop_after) begin
                in_valid = 1'b0;
                reset_check();
                break;
            end
            case (vmode)
                0: in_valid = 1'b1;
                1: in_valid = (n % 3 != 2);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data = (base != 0) ? base + 32'(k) + 1 : $urandom;
            step();
            n++;
        end
        if (n >= 600) tmo("load_busy");
        in_valid = 1'b0;
        cycles = n;
    endtask

    initial begin
        int cyc, d0, l0, a0;
        logic [31:0] saved16;
        for (int i = 0; i < 32; i++) begin
            rf[i]      = (i == 0) ? 32'h0 : 32'hA500_0000 + 32'(i);
            mdl_mem[i] = (i == 0) ? 32'h0 : 32'hA500_0000 + 32'(i);
        end
        rst = 1'b1; dump_req = 0; load_req = 0; out_ready = 0; in_valid = 0; in_data = 0;
        step();
        chk_en = 1;
        step();
        reset_check();

        // Full-rate load of 0x100+i, then full-rate dump
        d0 = done_cnt;
        run_load(0, -1, 32'h100, cyc);
        chk("load_min_cycles", cyc, 32);
        chk("load_done_once", done_cnt - d0, 1);
        chk("model_r5", mdl_mem[5], 32'h105);
        chk("model_r31", mdl_mem[31], 32'h11F);

        d0 = done_cnt; l0 = last_cnt;
        run_dump(0, -1, 0);
        chk("dump_beats", cap_data.size(), 32);
        chk("dump_done_once", done_cnt - d0, 1);
        chk("dump_last_once", last_cnt - l0, 1);
        if (cap_data.size() == 32) begin
            chk("dump_r0", cap_data[0], 32'h0);
            chk("dump_r7", cap_data[7], 32'h107);
            chk("dump_r31", cap_data[31], 32'h11F);
        end

        // Stalling consumer: order 0..31, nothing lost or duplicated
        run_dump(1, -1, 0);
        chk("stall_beats", cap_data.size(), 32);
        for (int i = 0; i < cap_addr.size(); i++) begin
            chk("stall_order", cap_addr[i], i);
            chk("stall_data", cap_data[i], (i == 0) ? 0 : 32'h100 + 32'(i));
        end

        // Gappy producer with random data
        a0 = acc_in;
        run_load(1, -1, 0, cyc);
        chk("gap_load_words", acc_in - a0, 31);

        // Simultaneous requests, load_req held through the dump
        run_dump(2, -1, 1);
        chk("both_dump_beats", cap_data.size(), 32);
        chk("both_no_load", acc_in - a0, 31);

        // Reset mid-dump after beat 10
        run_dump(0, 10, 0);
        chk("mid_dump_beats", cap_data.size(), 10);

        // Reset mid-load after word 15, then dump shows partial update
        saved16 = mdl_mem[16];
        run_load(0, 15, 32'h200, cyc);
        run_dump(0, -1, 0);
        if (cap_data.size() == 32) begin
            chk("partial_r1", cap_data[1], 32'h201);
            chk("partial_r15", cap_data[15], 32'h20F);
            chk("partial_r16", cap_data[16], saved16);
        end else begin
            chk("partial_beats", cap_data.size(), 32);
        end

        // Random mix of operations
        for (int t = 0; t < 8; t++) begin
            if ($urandom_range(0, 1) == 1) run_dump(2, -1, 0);
            else run_load(2, -1, 0, cyc);
            repeat ($urandom_range(0, 3)) step();
        end

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
